// File: rtl/apb_uart_duplex.sv
// Full-duplex APB3 UART peripheral.
//
// A zero-wait-state APB slave in front of a TX FIFO/serialiser and an RX
// deserialiser/FIFO. The baud divisor can be changed at run time. Errors are
// recorded in sticky write-one-to-clear status flags, and a registered
// level interrupt is provided.
//
// Ports:
//   clk        system clock; all logic runs on its rising edge
//   reset      asynchronous active-low reset
//   S_PADDR    word-indexed register select (0 DATA, 1 STATUS, 2 CTRL, 3 BAUD)
//   S_PWRITE   1 = write
//   S_PSELx    slave select
//   S_PENABLE  access phase
//   S_PWDATA   write data
//   S_PRDATA   read data; 0 outside a read access
//   S_PREADY   tied high
//   S_PSLVERR  error response: DATA write while TX is full, or DATA read while RX is empty
//   tx_wire    serial output, idle high
//   rx_wire    serial input, asynchronous to clk
//   irq        registered level interrupt
module apb_uart_duplex #(
    parameter int unsigned BUS_WIDTH      = 16,
    parameter int unsigned ADDR_WIDTH     = 2,
    parameter int unsigned DATA_BITS      = 8,
    parameter int unsigned TX_DEPTH       = 16,
    parameter int unsigned RX_DEPTH       = 16,
    parameter int unsigned BAUD_DIV_RESET = 434
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] S_PADDR,
    input  logic                  S_PWRITE,
    input  logic                  S_PSELx,
    input  logic                  S_PENABLE,
    input  logic [BUS_WIDTH-1:0]  S_PWDATA,
    output logic [BUS_WIDTH-1:0]  S_PRDATA,
    output logic                  S_PREADY,
    output logic                  S_PSLVERR,
    output logic                  tx_wire,
    input  logic                  rx_wire,
    output logic                  irq
);

    localparam int unsigned TAW = $clog2(TX_DEPTH);
    localparam int unsigned RAW = $clog2(RX_DEPTH);
    localparam logic [TAW:0] TxPtrOne = 1;
    localparam logic [RAW:0] RxPtrOne = 1;
    localparam logic [2:0]   LastBit  = 3'(DATA_BITS - 1);

    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop, RxWait} rx_state_e;

    // ---------------------------------------------------------------- APB decode
    logic access, wr, rd;
    logic sel_data, sel_status, sel_ctrl, sel_baud;
    logic wr_data, wr_status, wr_ctrl, wr_baud, rd_data;

    assign access     = S_PSELx & S_PENABLE;
    assign wr         = access & S_PWRITE;
    assign rd         = access & ~S_PWRITE;
    assign sel_data   = (S_PADDR == ADDR_WIDTH'(0));
    assign sel_status = (S_PADDR == ADDR_WIDTH'(1));
    assign sel_ctrl   = (S_PADDR == ADDR_WIDTH'(2));
    assign sel_baud   = (S_PADDR == ADDR_WIDTH'(3));
    assign wr_data    = wr & sel_data;
    assign wr_status  = wr & sel_status;
    assign wr_ctrl    = wr & sel_ctrl;
    assign wr_baud    = wr & sel_baud;
    assign rd_data    = rd & sel_data;

    // Upper write-data bits are architecturally ignored.
    logic unused_wdata;
    assign unused_wdata = ^S_PWDATA;

    // ---------------------------------------------------------------- registers
    logic [3:0]  ctrl_q;        // {irq_txe_en, irq_rx_en, rx_en, tx_en}
    logic [15:0] baud_q;
    logic        overrun_q, frame_err_q, irq_q;
    logic        tx_flush, rx_flush;

    assign tx_flush = wr_ctrl & S_PWDATA[4];
    assign rx_flush = wr_ctrl & S_PWDATA[5];

    // ---------------------------------------------------------------- TX FIFO
    logic [DATA_BITS-1:0] tx_mem [TX_DEPTH];
    logic [TAW:0]         tx_wptr_q, tx_rptr_q;
    logic                 tx_empty, tx_full, tx_push, tx_pop;
    logic [DATA_BITS-1:0] tx_head;

    assign tx_empty = (tx_wptr_q == tx_rptr_q);
    assign tx_full  = (tx_wptr_q[TAW] != tx_rptr_q[TAW]) &&
                      (tx_wptr_q[TAW-1:0] == tx_rptr_q[TAW-1:0]);
    assign tx_push  = wr_data & ~tx_full;
    assign tx_head  = tx_mem[tx_rptr_q[TAW-1:0]];

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr_q[TAW-1:0]] <= S_PWDATA[DATA_BITS-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
        end else if (tx_flush) begin
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
        end else begin
            if (tx_push) tx_wptr_q <= tx_wptr_q + TxPtrOne;
            if (tx_pop)  tx_rptr_q <= tx_rptr_q + TxPtrOne;
        end
    end

    // ---------------------------------------------------------------- TX FSM
    tx_state_e            tx_state_q, tx_state_d;
    logic [15:0]          tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
    logic [2:0]           tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_line_q, tx_line_d;
    logic                 tx_bit_end, tx_can_start, tx_start, tx_busy;

    assign tx_bit_end   = (tx_cnt_q == tx_div_q - 16'd1);
    assign tx_can_start = ctrl_q[0] & ~tx_empty;
    assign tx_busy      = (tx_state_q != TxIdle);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_div_d   = tx_div_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_line_d  = tx_line_q;
        tx_start   = 1'b0;
        case (tx_state_q)
            TxIdle: begin
                tx_line_d = 1'b1;
                tx_start  = tx_can_start;
            end
            TxStart: begin
                if (tx_bit_end) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_line_d  = tx_shift_q[0];
                    tx_state_d = TxData;
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            TxData: begin
                if (tx_bit_end) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == LastBit) begin
                        tx_line_d  = 1'b1;
                        tx_state_d = TxStop;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = tx_shift_q >> 1;
                        tx_line_d  = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            TxStop: begin
                if (tx_bit_end) begin
                    // Chain straight into the next frame so there is no idle gap.
                    if (tx_can_start) tx_start = 1'b1;
                    else              tx_state_d = TxIdle;
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            default: tx_state_d = TxIdle;
        endcase
        if (tx_start) begin
            tx_shift_d = tx_head;
            tx_div_d   = baud_q;
            tx_cnt_d   = '0;
            tx_line_d  = 1'b0;
            tx_state_d = TxStart;
        end
    end

    assign tx_pop = tx_start;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_div_q   <= 16'(BAUD_DIV_RESET);
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_line_q  <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_div_q   <= tx_div_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_line_q  <= tx_line_d;
        end
    end

    assign tx_wire = tx_line_q;

    // ---------------------------------------------------------------- RX sync + FSM
    logic rx_meta_q, rx_sync_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_wire;
            rx_sync_q <= rx_meta_q;
        end
    end

    rx_state_e            rx_state_q, rx_state_d;
    logic [15:0]          rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
    logic [2:0]           rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_done, rx_ferr_set, rx_bit_end;

    assign rx_bit_end = (rx_cnt_q == rx_div_q - 16'd1);

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_div_d    = rx_div_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_done     = 1'b0;
        rx_ferr_set = 1'b0;
        case (rx_state_q)
            RxIdle: begin
                if (ctrl_q[1] && !rx_sync_q) begin
                    rx_cnt_d   = '0;
                    rx_div_d   = baud_q;
                    rx_state_d = RxStart;
                end
            end
            RxStart: begin
                // Half a bit in: a line back high means the start edge was a glitch.
                if (rx_cnt_q == (rx_div_q >> 1) - 16'd1) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync_q ? RxIdle : RxData;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            RxData: begin
                if (rx_bit_end) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bit_q == LastBit) rx_state_d = RxStop;
                    else                     rx_bit_d   = rx_bit_q + 3'd1;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            RxStop: begin
                if (rx_bit_end) begin
                    rx_cnt_d = '0;
                    if (rx_sync_q) begin
                        rx_done    = 1'b1;
                        rx_state_d = RxIdle;
                    end else begin
                        rx_ferr_set = 1'b1;
                        rx_state_d  = RxWait;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            RxWait: begin
                // Stay out of IDLE until the break ends, so it is not seen as a start bit.
                if (rx_sync_q) rx_state_d = RxIdle;
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_div_q   <= 16'(BAUD_DIV_RESET);
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_div_q   <= rx_div_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    // ---------------------------------------------------------------- RX FIFO
    logic [DATA_BITS-1:0] rx_mem [RX_DEPTH];
    logic [RAW:0]         rx_wptr_q, rx_rptr_q, rx_count;
    logic                 rx_empty, rx_full, rx_push, rx_pop, rx_ovr_set;
    logic [31:0]          rx_level_wide;
    logic [7:0]           rx_level;

    assign rx_empty   = (rx_wptr_q == rx_rptr_q);
    assign rx_full    = (rx_wptr_q[RAW] != rx_rptr_q[RAW]) &&
                        (rx_wptr_q[RAW-1:0] == rx_rptr_q[RAW-1:0]);
    assign rx_pop     = rd_data & ~rx_empty;
    // A same-cycle pop frees the slot, so a full FIFO can still accept the byte.
    assign rx_push    = rx_done & (~rx_full | rx_pop);
    assign rx_ovr_set = rx_done & rx_full & ~rx_pop;
    assign rx_count   = rx_wptr_q - rx_rptr_q;
    assign rx_level_wide = 32'(rx_count);
    assign rx_level   = (rx_level_wide > 32'd255) ? 8'hFF : rx_level_wide[7:0];

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wptr_q[RAW-1:0]] <= rx_shift_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
        end else if (rx_flush) begin
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
        end else begin
            if (rx_push) rx_wptr_q <= rx_wptr_q + RxPtrOne;
            if (rx_pop)  rx_rptr_q <= rx_rptr_q + RxPtrOne;
        end
    end

    // ---------------------------------------------------------------- control/status
    logic irq_d;

    assign irq_d = (ctrl_q[2] & (~rx_empty | overrun_q | frame_err_q)) |
                   (ctrl_q[3] & tx_empty & ~tx_busy);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q      <= 4'b0011;
            baud_q      <= 16'(BAUD_DIV_RESET);
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            if (wr_ctrl) ctrl_q <= S_PWDATA[3:0];
            if (wr_baud) baud_q <= (S_PWDATA[15:0] < 16'd4) ? 16'd4 : S_PWDATA[15:0];
            // A new error in the same cycle as the clear keeps the flag set.
            overrun_q   <= (overrun_q & ~(wr_status & S_PWDATA[5])) | rx_ovr_set;
            frame_err_q <= (frame_err_q & ~(wr_status & S_PWDATA[6])) | rx_ferr_set;
            irq_q       <= irq_d;
        end
    end

    assign irq = irq_q;

    // ---------------------------------------------------------------- read path
    logic [15:0] rd_word;

    always_comb begin
        rd_word = '0;
        if (sel_data) begin
            rd_word = rx_empty ? 16'h0 : 16'(rx_mem[rx_rptr_q[RAW-1:0]]);
        end else if (sel_status) begin
            rd_word = {rx_level, 1'b0, frame_err_q, overrun_q, tx_busy,
                       rx_full, rx_empty, tx_empty, tx_full};
        end else if (sel_ctrl) begin
            rd_word = {12'h000, ctrl_q};
        end else if (sel_baud) begin
            rd_word = baud_q;
        end
    end

    assign S_PRDATA  = rd ? BUS_WIDTH'(rd_word) : '0;
    assign S_PREADY  = 1'b1;
    assign S_PSLVERR = access & sel_data & (S_PWRITE ? tx_full : rx_empty);

endmodule

// File: tb/tb_apb_uart_duplex.sv
// Directed-sequence bench with randomised data for apb_uart_duplex.
// Expected values come from queues of bytes and a status-word model built from FIFO
// occupancy counts. A free-running monitor decodes tx_wire back into bytes.
module tb_apb_uart_duplex;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  S_PADDR = '0;
    logic        S_PWRITE = 1'b0;
    logic        S_PSELx = 1'b0;
    logic        S_PENABLE = 1'b0;
    logic [15:0] S_PWDATA = '0;
    logic [15:0] S_PRDATA;
    logic        S_PREADY;
    logic        S_PSLVERR;
    logic        tx_wire;
    logic        rx_wire = 1'b1;
    logic        irq;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    apb_uart_duplex dut (
        .clk       (clk),
        .reset     (reset),
        .S_PADDR   (S_PADDR),
        .S_PWRITE  (S_PWRITE),
        .S_PSELx   (S_PSELx),
        .S_PENABLE (S_PENABLE),
        .S_PWDATA  (S_PWDATA),
        .S_PRDATA  (S_PRDATA),
        .S_PREADY  (S_PREADY),
        .S_PSLVERR (S_PSLVERR),
        .tx_wire   (tx_wire),
        .rx_wire   (rx_wire),
        .irq       (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One APB transfer; returns at the falling edge after the access-ending rising edge.
    task automatic apb(input logic wr, input logic [1:0] addr, input logic [15:0] wdata,
                       output logic [15:0] rdata, output logic slverr);
        @(negedge clk);
        S_PSELx = 1'b1; S_PENABLE = 1'b0; S_PWRITE = wr; S_PADDR = addr; S_PWDATA = wdata;
        @(negedge clk);
        S_PENABLE = 1'b1;
        #1;
        rdata  = S_PRDATA;
        slverr = S_PSLVERR;
        @(negedge clk);
        S_PSELx = 1'b0; S_PENABLE = 1'b0; S_PWRITE = 1'b0;
    endtask

    // Drive one serial frame on rx_wire; must be called at a falling edge.
    task automatic send_rx(input logic [7:0] b, input logic stop);
        rx_wire = 1'b0;
        repeat (D) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_wire = b[i];
            repeat (D) @(negedge clk);
        end
        rx_wire = stop;
        repeat (D) @(negedge clk);
        rx_wire = 1'b1;
    endtask

    // Status word predicted from FIFO occupancies and flag state.
    function automatic logic [15:0] exp_status(input int txn, input int rxn, input bit busy,
                                               input bit ovr, input bit ferr);
        logic [15:0] s;
        s       = '0;
        s[0]    = (txn == 16);
        s[1]    = (txn == 0);
        s[2]    = (rxn == 0);
        s[3]    = (rxn == 16);
        s[4]    = busy;
        s[5]    = ovr;
        s[6]    = ferr;
        s[15:8] = (rxn > 255) ? 8'hFF : 8'(rxn);
        return s;
    endfunction

    // TX line monitor: samples mid-bit, assuming divisor D.
    logic [7:0] tx_got[$];
    int         tx_bad = 0;
    bit         mon_en = 1'b0;

    initial begin : tx_mon
        logic [7:0] mb;
        forever begin
            @(negedge clk);
            if (mon_en && reset && tx_wire === 1'b0) begin
                repeat (D / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (D) @(negedge clk);
                    mb[i] = tx_wire;
                end
                repeat (D) @(negedge clk);
                if (tx_wire === 1'b1) tx_got.push_back(mb);
                else                  tx_bad++;
            end
        end
    end

    initial begin : main
        logic [15:0] rd;
        logic        err;
        logic [9:0]  frame;
        logic [7:0]  tx_exp[$];
        logic [7:0]  rx_exp[$];
        logic [7:0]  b;
        bit          ovr;
        int          waited;

        // ---- reset state
        repeat (3) @(negedge clk);
        check("rst_tx_wire", 32'(tx_wire), 32'd1);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_prdata", 32'(S_PRDATA), 32'd0);
        check("rst_pslverr", 32'(S_PSLVERR), 32'd0);
        check("pready", 32'(S_PREADY), 32'd1);
        reset = 1'b1;
        apb(1'b0, 2'd2, 16'h0, rd, err);
        check("rst_ctrl", 32'(rd), 32'h0003);
        apb(1'b0, 2'd3, 16'h0, rd, err);
        check("rst_baud", 32'(rd), 32'd434);
        apb(1'b0, 2'd1, 16'h0, rd, err);
        check("rst_status", 32'(rd), 32'(exp_status(0, 0, 0, 0, 0)));

        // ---- baud clamp, then D=4
        apb(1'b1, 2'd3, 16'd2, rd, err);
        apb(1'b0, 2'd3, 16'h0, rd, err);
        check("baud_clamp", 32'(rd), 32'd4);
        apb(1'b1, 2'd3, 16'(D), rd, err);

        // ---- test 1: exact waveform of 0xA5
        apb(1'b1, 2'd0, 16'h00A5, rd, err);
        check("t1_wr_err", 32'(err), 32'd0);
        check("t1_idle_before", 32'(tx_wire), 32'd1);
        frame = {1'b1, 8'hA5, 1'b0};
        for (int k = 1; k <= 42; k++) begin
            @(negedge clk);
            if (k <= 10 * D) check($sformatf("t1_bit_cyc%0d", k), 32'(tx_wire),
                                   32'(frame[(k - 1) / D]));
            else             check($sformatf("t1_idle_cyc%0d", k), 32'(tx_wire), 32'd1);
        end
        apb(1'b0, 2'd1, 16'h0, rd, err);
        check("t1_status_after", 32'(rd), 32'(exp_status(0, 0, 0, 0, 0)));

        // ---- test 2: receive 0x3C
        send_rx(8'h3C, 1'b1);
        repeat (3 * D) @(negedge clk);
        apb(1'b0, 2'd1, 16'h0, rd, err);
        check("t2_status", 32'(rd), 32'(exp_status(0, 1, 0, 0, 0)));
        apb(1'b0, 2'd0, 16'h0, rd, err);
        check("t2_data", 32'(rd), 32'h003C);
        check("t2_data_err", 32'(err), 32'd0);
        apb(1'b0, 2'd0, 16'h0, rd, err);
        check("t2_empty_data", 32'(rd), 32'h0000);
        check("t2_empty_err", 32'(err), 32'd1);

        // ---- test 3: fill TX while disabled, then release
        apb(1'b1, 2'd2, 16'h0002, rd, err);
        for (int i = 0; i < 17; i++) begin
            b = 8'($urandom);
            apb(1'b1, 2'd0, {8'h00, b}, rd, err);
            if (i < 16) tx_exp.push_back(b);
            check($sformatf("t3_wr_err%0d", i), 32'(err), (i == 16) ? 32'd1 : 32'd0);
        end
        apb(1'b0, 2'd1, 16'h0, rd, err);
        check("t3_status_full", 32'(rd), 32'(exp_status(16, 0, 0, 0, 0)));
        mon_en = 1'b1;
        apb(1'b1, 2'd2, 16'h0003, rd, err);
        waited = 0;
        while (tx_got.size() < 16 && waited < 16 * 10 * D + 200) begin
            @(negedge clk);
            waited++;
        end
        check("t3_frame_count", 32'(tx_got.size()), 32'd16);
        while (tx_got.size() > 0 && tx_exp.size() > 0)
            check("t3_frame_byte", 32'(tx_got.pop_front()), 32'(tx_exp.pop_front()));
        repeat (2 * D) @(negedge clk);
        apb(1'b0, 2'd1, 16'h0, rd, err);
        check("t3_status_done", 32'(rd), 32'(exp_status(0, 0, 0, 0, 0)));

        // ---- test 4: 17 RX frames, overrun
        ovr = 1'b0;
        for (int i = 0; i < 17; i++) begin
            b = 8'($urandom);
            send_rx(b, 1'b1);
            if (rx_exp.size() < 16) rx_exp.push_back(b);
            else                    ovr = 1'b1;
        end
        repeat (3 * D) @(negedge clk);
        apb(1'b0, 2'd1, 16'h0, rd, err);
        check("t4_status_ovr", 32'(rd), 32'(exp_status(0, rx_exp.size(), 0, ovr, 0)));
        apb(1'b1, 2'd1, 16'h0020, rd, err);
        apb(1'b0, 2'd1, 16'h0, rd, err);
        check("t4_status_w1c", 32'(rd), 32'(exp_status(0, rx_exp.size(), 0, 0, 0)));
        while (rx_exp.size() > 0) begin
            apb(1'b0, 2'd0, 16'h0, rd, err);
            check("t4_rx_byte", 32'(rd), 32'(rx_exp.pop_front()));
            check("t4_rx_err", 32'(err), 32'd0);
        end
        apb(1'b0, 2'd1, 16'h0, rd, err);
        check("t4_status_drained", 32'(rd), 32'(exp_status(0, 0, 0, 0, 0)));

        // ---- test 5: framing error, glitch rejection
        send_rx(8'($urandom), 1'b0);
        repeat (3 * D) @(negedge clk);
        apb(1'b0, 2'd1, 16'h0, rd, err);
        check("t5_status_ferr", 32'(rd), 32'(exp_status(0, 0, 0, 0, 1)));
        apb(1'b1, 2'd1, 16'h0040, rd, err);
        apb(1'b0, 2'd1, 16'h0, rd, err);
        check("t5_status_w1c", 32'(rd), 32'(exp_status(0, 0, 0, 0, 0)));
        rx_wire = 1'b0;
        @(negedge clk);
        rx_wire = 1'b1;
        repeat (20) @(negedge clk);
        apb(1'b0, 2'd1, 16'h0, rd, err);
        check("t5_status_glitch", 32'(rd), 32'(exp_status(0, 0, 0, 0, 0)));
        b = 8'($urandom);
        send_rx(b, 1'b1);
        repeat (3 * D) @(negedge clk);
        apb(1'b0, 2'd0, 16'h0, rd, err);
        check("t5_rx_after_glitch", 32'(rd), 32'(b));

        // ---- test 6: tx-empty interrupt timing
        apb(1'b1, 2'd2, 16'h000B, rd, err);
        check("t6_irq_lag", 32'(irq), 32'd0);
        @(negedge clk);
        check("t6_irq_idle", 32'(irq), 32'd1);
        b = 8'($urandom);
        apb(1'b1, 2'd0, {8'h00, b}, rd, err);
        check("t6_irq_at_push", 32'(irq), 32'd1);
        for (int k = 1; k <= 10 * D + 2; k++) begin
            @(negedge clk);
            check($sformatf("t6_irq_cyc%0d", k), 32'(irq), (k <= 10 * D + 1) ? 32'd0 : 32'd1);
        end
        repeat (D) @(negedge clk);
        check("t6_tx_frame_count", 32'(tx_got.size()), 32'd1);
        if (tx_got.size() > 0) check("t6_tx_byte", 32'(tx_got.pop_front()), 32'(b));

        // ---- test 6b: reset mid-frame with irq asserted
        mon_en = 1'b0;
        apb(1'b1, 2'd2, 16'h0007, rd, err);
        send_rx(8'($urandom), 1'b1);
        repeat (3 * D) @(negedge clk);
        apb(1'b1, 2'd0, 16'h0000, rd, err);
        repeat (2 * D) @(negedge clk);
        check("t6_tx_low_midframe", 32'(tx_wire), 32'd0);
        check("t6_irq_pre_reset", 32'(irq), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("t6_rst_tx_wire", 32'(tx_wire), 32'd1);
        check("t6_rst_irq", 32'(irq), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        apb(1'b0, 2'd2, 16'h0, rd, err);
        check("t6_rst_ctrl", 32'(rd), 32'h0003);
        apb(1'b0, 2'd3, 16'h0, rd, err);
        check("t6_rst_baud", 32'(rd), 32'd434);
        apb(1'b0, 2'd1, 16'h0, rd, err);
        check("t6_rst_status", 32'(rd), 32'(exp_status(0, 0, 0, 0, 0)));
        apb(1'b0, 2'd0, 16'h0, rd, err);
        check("t6_rst_rx_err", 32'(err), 32'd1);
        check("t6_rst_tx_idle", 32'(tx_wire), 32'd1);
        check("tx_stop_bits", 32'(tx_bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
